// File: rtl/mips_cpu_muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer and HI/LO register owner.
// Iterative shift-add multiply and restoring divide, one bit per cycle.
// Ports: clk, rst_n (async low); start_i/op_i/a_i/b_i issue a request;
//   busy_o stalls the core; done_o pulses when HI/LO take a mul/div result;
//   hi_o/lo_o are the architectural HI/LO; div_zero_o flags a zero divisor.
// Option: MIPS_MULDIV_DIVZERO_FAST_EN short-circuits divide-by-zero
//   (PREP -> FIXUP) and drives div_zero_o; otherwise div_zero_o is 0.
module mips_cpu_muldiv_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PREP  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FIXUP = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             op_div;
    logic             op_sgn;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             done;
`ifdef MIPS_MULDIV_DIVZERO_FAST_EN
    logic             dz;
`endif

    // Request decode (only meaningful in IDLE)
    logic start_md;
    logic start_mthi;
    logic start_mtlo;

    assign start_md   = start_i && !op_i[2];
    assign start_mthi = start_i && (op_i == 3'b100);
    assign start_mtlo = start_i && (op_i == 3'b101);

    // Magnitudes of the latched raw operands
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign sa    = op_sgn && opa[WIDTH-1];
    assign sb    = op_sgn && opb[WIDTH-1];
    assign abs_a = sa ? -opa : opa;
    assign abs_b = sb ? -opb : opb;

    // Multiply step: conditional add into upper half, then shift right.
    // The carry out of the add becomes the new MSB of the accumulator.
    logic [WIDTH:0] mul_sum;

    assign mul_sum = {1'b0, acc} + (q[0] ? {1'b0, opb} : '0);

    // Divide step: shift {rem,quo} left, subtract divisor when it fits.
    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] rem_nx;

    assign rem_sh = {acc, q[WIDTH-1]};
    assign ge     = rem_sh >= {1'b0, opb};
    assign rem_nx = ge ? (rem_sh[WIDTH-1:0] - opb) : rem_sh[WIDTH-1:0];

    // Sign fixup of the final magnitudes
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_f;
    logic [WIDTH-1:0]   quo_raw;
    logic [WIDTH-1:0]   rem_raw;
    logic [WIDTH-1:0]   quo_f;
    logic [WIDTH-1:0]   rem_f;

    assign prod   = {acc, q};
    assign prod_f = neg_q ? -prod : prod;

`ifdef MIPS_MULDIV_DIVZERO_FAST_EN
    // Skipped iterations: produce what the restoring loop would have
    assign quo_raw = dz ? {WIDTH{1'b1}} : q;
    assign rem_raw = dz ? q : acc;
`else
    assign quo_raw = q;
    assign rem_raw = acc;
`endif

    assign quo_f = neg_q ? -quo_raw : quo_raw;
    assign rem_f = neg_r ? -rem_raw : rem_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_div <= 1'b0;
            op_sgn <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            q      <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
`ifdef MIPS_MULDIV_DIVZERO_FAST_EN
            dz     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MIPS_MULDIV_DIVZERO_FAST_EN
            dz   <= dz && (state != S_FIXUP);
`endif
            case (state)
                S_IDLE: begin
                    if (start_md) begin
                        op_div <= op_i[1];
                        op_sgn <= !op_i[0];
                        opa    <= a_i;
                        opb    <= b_i;
                        state  <= S_PREP;
                    end else if (start_mthi) begin
                        hi <= a_i;
                    end else if (start_mtlo) begin
                        lo <= a_i;
                    end
                end
                S_PREP: begin
                    acc   <= '0;
                    cnt   <= '0;
                    neg_q <= sa ^ sb;
                    neg_r <= op_div && sa;
                    if (op_div) begin
                        q   <= abs_a;
                        opb <= abs_b;
                    end else begin
                        q   <= abs_b;
                        opb <= abs_a;
                    end
                    state <= S_RUN;
`ifdef MIPS_MULDIV_DIVZERO_FAST_EN
                    if (op_div && (opb == '0)) begin
                        dz    <= 1'b1;
                        state <= S_FIXUP;
                    end
`endif
                end
                S_RUN: begin
                    if (op_div) begin
                        acc <= rem_nx;
                        q   <= {q[WIDTH-2:0], ge};
                    end else begin
                        acc <= mul_sum[WIDTH:1];
                        q   <= {mul_sum[0], q[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= S_FIXUP;
                    end
                end
                default: begin
                    if (op_div) begin
                        hi <= rem_f;
                        lo <= quo_f;
                    end else begin
                        hi <= prod_f[2*WIDTH-1:WIDTH];
                        lo <= prod_f[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state != S_IDLE);
    assign done_o = done;
    assign hi_o   = hi;
    assign lo_o   = lo;

`ifdef MIPS_MULDIV_DIVZERO_FAST_EN
    logic dz_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dz_pulse <= 1'b0;
        end else begin
            dz_pulse <= dz && (state == S_FIXUP);
        end
    end

    assign div_zero_o = dz_pulse;
`else
    assign div_zero_o = 1'b0;
`endif

endmodule

// File: tb/tb_mips_cpu_muldiv_ctrl.sv
// Scoreboard bench for mips_cpu_muldiv_ctrl.
// Stimulus pushes expected HI/LO/latency; a negedge monitor checks on done_o.
module tb_mips_cpu_muldiv_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        div_zero_o;

    mips_cpu_muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .op_i       (op_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .div_zero_o (div_zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

`ifdef MIPS_MULDIV_DIVZERO_FAST_EN
    localparam int  DZ_LAT = 3;
    localparam bit  DZ_FLG = 1'b1;
`else
    localparam int  DZ_LAT = 35;
    localparam bit  DZ_FLG = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          issue;
        int          lat;
        logic        dz;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: compares every done_o pulse against the queue head
    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: hi=%0h lo=%0h", hi_o, lo_o);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk({e.name, "_hi"}, 64'(hi_o), 64'(e.hi));
                chk({e.name, "_lo"}, 64'(lo_o), 64'(e.lo));
                chk({e.name, "_lat"}, 64'(cyc - e.issue), 64'(e.lat));
                chk({e.name, "_dz"}, 64'(div_zero_o), 64'(e.dz));
            end
        end else if (rst_n && div_zero_o) begin
            checks++;
            failures++;
            $display("FAIL dz_without_done: div_zero_o=1 done_o=0");
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit push,
                         input string nm, input logic [31:0] ehi,
                         input logic [31:0] elo, input int lat,
                         input logic dz);
        exp_t e;
        @(negedge clk);
        start_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        if (push) begin
            e.name  = nm;
            e.hi    = ehi;
            e.lo    = elo;
            e.issue = cyc;
            e.lat   = lat;
            e.dz    = dz;
            sbq.push_back(e);
        end
        @(negedge clk);
        start_i = 1'b0;
        a_i     = $urandom;
        b_i     = $urandom;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 80 && sbq.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: pending=%0d required=0",
                     nm, sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int nb;
        rst_n   = 1'b0;
        start_i = 1'b0;
        op_i    = 3'b000;
        a_i     = '0;
        b_i     = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_hi", 64'(hi_o), 64'd0);
        chk("rst_lo", 64'(lo_o), 64'd0);
        chk("rst_dz", 64'(div_zero_o), 64'd0);
        rst_n = 1'b1;

        // MTHI / MTLO write directly, no busy/done
        issue(OP_MTHI, 32'h1234, 32'h0, 0, "", '0, '0, 0, 0);
        chk("mthi_hi", 64'(hi_o), 64'h1234);
        chk("mthi_busy", 64'(busy_o), 64'd0);
        chk("mthi_done", 64'(done_o), 64'd0);
        issue(OP_MTLO, 32'hABCD, 32'h0, 0, "", '0, '0, 0, 0);
        chk("mtlo_lo", 64'(lo_o), 64'hABCD);
        chk("mtlo_hi_kept", 64'(hi_o), 64'h1234);
        chk("mtlo_busy", 64'(busy_o), 64'd0);

        // Unknown op ignored
        issue(3'b111, 32'h55, 32'h66, 0, "", '0, '0, 0, 0);
        chk("unk_busy", 64'(busy_o), 64'd0);
        chk("unk_hi", 64'(hi_o), 64'h1234);

        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, "multu_max",
              32'hFFFFFFFE, 32'h00000001, 35, 0);
        chk("busy_hold_hi", 64'(hi_o), 64'h1234);
        drain("multu_max");

        // MULT -3*7, busy exactly 34 cycles
        issue(OP_MULT, 32'hFFFFFFFD, 32'd7, 1, "mult_neg",
              32'hFFFFFFFF, 32'hFFFFFFEB, 35, 0);
        nb = 0;
        for (int i = 0; i < 60; i++) begin
            if (busy_o) nb++;
            @(negedge clk);
        end
        chk("mult_busy_cycles", 64'(nb), 64'd34);
        drain("mult_neg");

        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1, "div_neg",
              32'hFFFFFFFF, 32'hFFFFFFFD, 35, 0);
        drain("div_neg");
        issue(OP_DIVU, 32'd100, 32'd7, 1, "divu",
              32'd2, 32'd14, 35, 0);
        drain("divu");
        issue(OP_DIV, 32'd7, 32'hFFFFFFFE, 1, "div_negb",
              32'd1, 32'hFFFFFFFD, 35, 0);
        drain("div_negb");
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1, "div_ovf",
              32'd0, 32'h80000000, 35, 0);
        drain("div_ovf");
        issue(OP_MULT, 32'h80000000, 32'h80000000, 1, "mult_minmin",
              32'h40000000, 32'h0, 35, 0);
        drain("mult_minmin");

        // Divide by zero
        issue(OP_DIVU, 32'd5, 32'd0, 1, "divu_zero",
              32'd5, 32'hFFFFFFFF, DZ_LAT, DZ_FLG);
        drain("divu_zero");
        issue(OP_DIV, 32'hFFFFFFF8, 32'd0, 1, "div_zero_neg",
              32'hFFFFFFF8, 32'd1, DZ_LAT, DZ_FLG);
        drain("div_zero_neg");

        // Requests during busy are ignored
        issue(OP_MULTU, 32'h12345678, 32'h10, 1, "multu_busy",
              32'h1, 32'h23456780, 35, 0);
        repeat (3) @(negedge clk);
        issue(OP_MULT, 32'd100, 32'd100, 0, "", '0, '0, 0, 0);
        issue(OP_MTHI, 32'hDEAD, 32'h0, 0, "", '0, '0, 0, 0);
        drain("multu_busy");
        repeat (40) @(negedge clk);
        chk("busy_ign_hi", 64'(hi_o), 64'h1);
        chk("busy_ign_lo", 64'(lo_o), 64'h23456780);

        // Reset in the middle of RUN
        issue(OP_MULT, 32'd5, 32'd5, 0, "", '0, '0, 0, 0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_hi", 64'(hi_o), 64'd0);
        chk("abort_lo", 64'(lo_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(OP_MULT, 32'hFFFFFFFC, 32'hFFFFFFFB, 1, "mult_after_rst",
              32'd0, 32'd20, 35, 0);
        drain("mult_after_rst");
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
